alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised, two-stage pipelined ALU; successor to the 4-bit combinational ALU.
//  Generalises width and op set. Adds SUB-based SLT, XOR and shifts.
//  Adds a valid/ready handshake, backpressure, and sticky overflow/carry status.
//  Sits between operand fetch and writeback in the datapath.
// PARAMETERS
//  WIDTH    32  operand/result width in bits (>=4)
//  SHAMT_W  $clog2(WIDTH)  shift-amount bits taken from b[SHAMT_W-1:0]
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  in_valid    in   1      operand beat valid
//  in_ready    out  1      block can accept a beat
//  a, b        in   WIDTH  operands
//  op          in   3      alu_op_t, see BEHAVIOUR
//  out_valid   out  1      result beat valid
//  out_ready   in   1      consumer accepts result
//  y           out  WIDTH  result
//  zero,neg    out  1      y==0 ; y[WIDTH-1]
//  carry,ovf   out  1      carry-out / signed overflow for this result
//  clr_sticky  in   1      clear sticky flags (level, sampled on clk)
//  sticky_ovf  out  1      OR of ovf over all transferred results since clear
//  sticky_cy   out  1      OR of carry over all transferred results since clear
// BEHAVIOUR
//  Ops: 0 ADD a+b; 1 SUB a+~b+1; 2 AND; 3 OR; 4 XOR; 5 SLT (signed a<b -> 1 else 0);
//   6 SLL a<<shamt; 7 SRL a>>shamt (logical).
//  Arith: {carry,sum} = a + (sub?~b:b) + sub, all WIDTH+1 bits.
//   SUB carry=1 means no borrow. carry=0 for ops 2,3,4,6,7.
//  ovf ADD: a,b same sign and sum sign differs. ovf SUB: a,b differ in sign and sum sign != a sign.
//   ovf=0 for all other ops. SLT = sum[MSB]^ovf_sub, using the SUB adder. carry, ovf reported as SUB.
//  zero, neg always from final y, for every op.
//  Stage 1 registers a,b,op on in_valid&&in_ready. Stage 2 registers y and flags.
//  Latency: beat accepted at edge N -> out_valid at edge N+2 when not stalled.
//  Throughput 1 beat/clk.
//  Handshake: stage2 advances iff !out_valid || out_ready.
//   Stage1 advances iff !s1_valid || stage2 advances. in_ready = that stage1 condition (combinational).
//  Stall: out_valid&&!out_ready holds y and flags stable, no drop, no duplicate.
//  Beats leave in order.
//  Sticky: on out_valid&&out_ready, sticky |= {ovf,carry}.
//   clr_sticky same cycle: sticky <= flags of that transfer only (clear acts on old value).
//   clr_sticky without transfer: sticky <= 0.
//  Reset (any time, incl. mid-stall): s1_valid=0, out_valid=0, y=0, all flags=0, sticky=0.
//   In-flight beats are discarded. in_ready=1 once reset releases.
//  Data regs may be held without reset. Outputs above must read 0 during reset.
// STRUCTURE
//  alu_pkg: typedef enum logic[2:0] alu_op_t {OP_ADD..OP_SRL}; typedef struct flags_t {zero,neg,carry,ovf}.
//  Sub-module alu_core #(WIDTH): purely combinational a,b,op -> y,flags_t.
//   Instantiated between stage1 and stage2 regs. alu_pipe holds only the handshake, pipeline regs and sticky.
// TESTING
//  ADD 0x7FFFFFFF+0x1, out_ready=1 -> 2 clk later y=0x80000000, ovf=1, neg=1, carry=0, zero=0.
//  SUB 5-5 -> y=0, zero=1, carry=1, ovf=0. SUB 0-1 -> y=0xFFFFFFFF, carry=0, neg=1.
//  SLT 0xFFFFFFFF,0x1 -> y=1. SLT 0x80000000,0x7FFFFFFF -> y=1. SLL 0x1 by b=35 -> y=0x8 (shamt=3).
//  Back-to-back 4 beats, out_ready low 3 clk mid-stream -> y holds, in_ready drops after 2 buffered.
//   All 4 results are delivered in order.
//  Overflowing ADD transferred -> sticky_ovf=1. Next 3 ANDs keep sticky_ovf=1.
//   clr_sticky with overflowing SUB transfer -> sticky_ovf=1. Lone clr_sticky -> 0.
//  rst_n low while out_valid=1 and stalled -> out_valid, y, flags, sticky 0 asynchronously.
//   After release, first new beat result appears at N+2.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the pipelined ALU.
//   alu_op_t : 3-bit operation select (ADD, SUB, AND, OR, XOR, SLT, SLL, SRL)
//   flags_t  : per-result status {zero, neg, carry, ovf}
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLT = 3'd5,
    OP_SLL = 3'd6,
    OP_SRL = 3'd7
  } alu_op_t;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
  } flags_t;

  // SLT is evaluated on the subtracting adder, so it shares SUB's operand inversion.
  function automatic logic is_sub_op(alu_op_t op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result bus of the pipelined ALU.
//   slave  : the ALU side (accepts operand beats, produces result beats)
//   master : the producer/consumer side
// Handshake: a beat moves across a valid/ready pair on a rising clk edge
// exactly when valid and ready are both high. A producer holding valid high
// keeps its payload stable until the transfer. ready may depend
// combinationally on the downstream ready; valid never depends on ready.
interface alu_pipe_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  alu_op_t          op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             neg;
  logic             carry;
  logic             ovf;
  logic             clr_sticky;
  logic             sticky_ovf;
  logic             sticky_cy;

  modport slave (
    input  in_valid, a, b, op, out_ready, clr_sticky,
    output in_ready, out_valid, y, zero, neg, carry, ovf, sticky_ovf, sticky_cy
  );

  modport master (
    output in_valid, a, b, op, out_ready, clr_sticky,
    input  in_ready, out_valid, y, zero, neg, carry, ovf, sticky_ovf, sticky_cy
  );

endinterface

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU datapath.
//   a, b  : operands (WIDTH bits)
//   op    : alu_op_t
//   y     : result
//   flags : {zero, neg, carry, ovf} of this result
// One WIDTH+1-bit adder serves ADD, SUB and SLT; shifts use b[SHAMT_W-1:0].
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  output logic [WIDTH-1:0] y,
  output flags_t           flags
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int MSB     = WIDTH - 1;

  logic               sub;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic               ovf_add;
  logic               ovf_sub;
  logic [SHAMT_W-1:0] shamt;

  assign sub   = is_sub_op(op);
  assign b_eff = sub ? ~b : b;
  // For SUB, cout=1 means no borrow (a >= b unsigned).
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

  assign ovf_add = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
  assign ovf_sub = (a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]);
  assign shamt   = b[SHAMT_W-1:0];

  always_comb begin
    y           = '0;
    flags.carry = 1'b0;
    flags.ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        y           = sum;
        flags.carry = cout;
        flags.ovf   = ovf_add;
      end
      OP_SUB: begin
        y           = sum;
        flags.carry = cout;
        flags.ovf   = ovf_sub;
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_SLT: begin
        // Signed less-than: the difference's sign, corrected when it overflowed.
        y           = {{(WIDTH-1){1'b0}}, sum[MSB] ^ ovf_sub};
        flags.carry = cout;
        flags.ovf   = ovf_sub;
      end
      OP_SLL: y = a << shamt;
      OP_SRL: y = a >> shamt;
      default: y = '0;
    endcase
    flags.zero = (y == '0);
    flags.neg  = y[MSB];
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready flow control and sticky
// overflow/carry status.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (discards in-flight beats)
//   bus   : alu_pipe_if.slave -- operand beat in (in_valid/in_ready, a, b, op),
//           result beat out (out_valid/out_ready, y, zero, neg, carry, ovf),
//           clr_sticky in, sticky_ovf/sticky_cy out
// Stage 1 holds the operands; alu_core sits between stage 1 and stage 2;
// stage 2 holds the result and its flags until the consumer takes them.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  alu_pipe_if.slave bus
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  alu_op_t          s1_op;

  logic [WIDTH-1:0] core_y;
  flags_t           core_flags;

  logic             out_valid_q;
  logic [WIDTH-1:0] y_q;
  flags_t           flags_q;
  logic             sticky_ovf_q;
  logic             sticky_cy_q;

  logic             s2_adv;
  logic             s1_adv;
  logic             xfer;

  // Each stage may load whenever it is empty or its content leaves this cycle,
  // which gives full throughput and stops cleanly under backpressure.
  assign s2_adv = !out_valid_q || bus.out_ready;
  assign s1_adv = !s1_valid || s2_adv;
  assign xfer   = out_valid_q && bus.out_ready;

  assign bus.in_ready = s1_adv;

  // Stage 1: operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
    end
  end

  // Operand data is qualified by s1_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (bus.in_valid && s1_adv) begin
      s1_a  <= bus.a;
      s1_b  <= bus.b;
      s1_op <= bus.op;
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a     (s1_a),
    .b     (s1_b),
    .op    (s1_op),
    .y     (core_y),
    .flags (core_flags)
  );

  // Stage 2: result registers. Reset because they drive the outputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      flags_q     <= '0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        y_q     <= core_y;
        flags_q <= core_flags;
      end
    end
  end

  // Sticky status. A clear discards the old value but still records a
  // transfer happening in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf_q <= 1'b0;
      sticky_cy_q  <= 1'b0;
    end else if (bus.clr_sticky) begin
      sticky_ovf_q <= xfer && flags_q.ovf;
      sticky_cy_q  <= xfer && flags_q.carry;
    end else if (xfer) begin
      sticky_ovf_q <= sticky_ovf_q | flags_q.ovf;
      sticky_cy_q  <= sticky_cy_q  | flags_q.carry;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.y          = y_q;
  assign bus.zero       = flags_q.zero;
  assign bus.neg        = flags_q.neg;
  assign bus.carry      = flags_q.carry;
  assign bus.ovf        = flags_q.ovf;
  assign bus.sticky_ovf = sticky_ovf_q;
  assign bus.sticky_cy  = sticky_cy_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed bench for alu_pipe (WIDTH=32) with a behavioural
// result model, a result queue and sticky model checked every falling edge.
module tb_alu_pipe;
  import alu_pkg::*;

  logic clk;
  logic rst_n;

  alu_pipe_if #(.WIDTH(32)) bus ();

  alu_pipe #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  // Packed expected entry: {y[31:0], zero, neg, carry, ovf}
  logic [35:0] exp_q[$];
  logic [1:0]  m_sticky = 2'b00;   // {ovf, carry}

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  function automatic void chk(string name, logic [35:0] act, logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endfunction

  function automatic void fail_event(string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur as required", name);
  endfunction

  // Result model computed from arithmetic on the integer values of a and b.
  function automatic logic [35:0] model(logic [31:0] a, logic [31:0] b, logic [2:0] op);
    longint      sa, sb, ua, ub, r;
    logic [31:0] y;
    logic        c, o;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    y = 32'd0;
    c = 1'b0;
    o = 1'b0;
    case (op)
      3'd0: begin
        y = a + b;
        c = (ua + ub) > 64'sd4294967295;
        r = sa + sb;
        o = (r > SMAX) || (r < SMIN);
      end
      3'd1: begin
        y = a - b;
        c = (ua >= ub);
        r = sa - sb;
        o = (r > SMAX) || (r < SMIN);
      end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: begin
        y = (sa < sb) ? 32'd1 : 32'd0;
        c = (ua >= ub);
        r = sa - sb;
        o = (r > SMAX) || (r < SMIN);
      end
      3'd6: y = a << (b % 32);
      default: y = a >> (b % 32);
    endcase
    return {y, (y == 32'd0), y[31], c, o};
  endfunction

  // ---------------- directed vector table ----------------
  // Expected y and {zero,neg,carry,ovf} worked out by hand.
  localparam int NV = 12;
  logic [31:0] t_a  [NV] = '{32'hFFFFFFFF, 32'd5, 32'd0, 32'h0F0F0F0F, 32'h80000000, 32'hF0F0F0F0,
                             32'hFFFFFFFF, 32'h80000000, 32'd1, 32'd1, 32'h80000000, 32'h80000000};
  logic [31:0] t_b  [NV] = '{32'd1, 32'd5, 32'd1, 32'hF0F0F0F0, 32'd1, 32'hFF00FF00,
                             32'd1, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd35, 32'd4, 32'h3F};
  logic [2:0]  t_op [NV] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4,
                             3'd5, 3'd5, 3'd5, 3'd6, 3'd7, 3'd7};
  logic [31:0] t_y  [NV] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'd0, 32'h80000001, 32'h0FF00FF0,
                             32'd1, 32'd1, 32'd0, 32'd8, 32'h08000000, 32'd1};
  logic [3:0]  t_f  [NV] = '{4'b1010, 4'b1010, 4'b0100, 4'b1000, 4'b0100, 4'b0000,
                             4'b0010, 4'b0011, 4'b1000, 4'b0000, 4'b0000, 4'b0000};

  // ---------------- scoreboard / compare process ----------------
  // Runs on the falling edge, when inputs and outputs are both settled. The
  // queue holds every accepted beat not yet taken by the consumer.
  always @(negedge clk) begin
    logic [35:0] f;
    logic        xfer;
    if (!rst_n) begin
      chk("rst_out_valid", 36'(bus.out_valid), 36'd0);
      chk("rst_y", 36'(bus.y), 36'd0);
      chk("rst_flags", 36'({bus.zero, bus.neg, bus.carry, bus.ovf}), 36'd0);
      chk("rst_sticky", 36'({bus.sticky_ovf, bus.sticky_cy}), 36'd0);
      exp_q.delete();
      m_sticky = 2'b00;
    end else begin
      chk("in_ready", 36'(bus.in_ready), 36'((exp_q.size() < 2) || bus.out_ready));
      chk("sticky", 36'({bus.sticky_ovf, bus.sticky_cy}), 36'(m_sticky));
      f = '0;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) fail_event("unexpected_out_valid");
        else begin
          chk("y", 36'(bus.y), 36'(exp_q[0][35:4]));
          chk("flags", 36'({bus.zero, bus.neg, bus.carry, bus.ovf}), 36'(exp_q[0][3:0]));
        end
      end
      xfer = bus.out_valid && bus.out_ready && (exp_q.size() > 0);
      if (xfer) f = exp_q.pop_front();
      if (bus.clr_sticky) m_sticky = xfer ? {f[0], f[1]} : 2'b00;
      else if (xfer)      m_sticky = m_sticky | {f[0], f[1]};
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.a, bus.b, bus.op));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Present a beat and hold it until accepted; returns 1 time unit after the
  // accepting edge so a following send keeps the stream back-to-back.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    bit got;
    got = 1'b0;
    bus.a = a;
    bus.b = b;
    bus.op = alu_op_t'(op);
    bus.in_valid = 1'b1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_event("send_timeout");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Returns on a falling edge with out_valid high.
  task automatic wait_out();
    bit got;
    got = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_event("out_valid_timeout");
  endtask

  task automatic run_vec(input int i);
    align();
    send(t_a[i], t_b[i], t_op[i]);
    wait_out();
    chk($sformatf("vec%0d_y", i), 36'(bus.y), 36'(t_y[i]));
    chk($sformatf("vec%0d_flags", i), 36'({bus.zero, bus.neg, bus.carry, bus.ovf}), 36'(t_f[i]));
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if ((exp_q.size() == 0) && !bus.out_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) fail_event("drain_timeout");
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- main sequence ----------------
  int          stall_idx [4] = '{2, 4, 5, 10};
  logic [31:0] held_y;

  initial begin
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.op         = OP_ADD;
    bus.out_ready  = 1'b0;
    bus.clr_sticky = 1'b0;

    // Pin the model against the hand-worked table.
    for (int i = 0; i < NV; i++)
      chk($sformatf("model%0d", i), model(t_a[i], t_b[i], t_op[i]), {t_y[i], t_f[i]});

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 36'(bus.in_ready), 36'd1);
    chk("post_rst_out_valid", 36'(bus.out_valid), 36'd0);

    // Overflowing ADD: latency and flags.
    align();
    bus.out_ready = 1'b1;
    send(32'h7FFFFFFF, 32'h1, 3'd0);
    @(negedge clk);
    chk("lat_one_edge", 36'(bus.out_valid), 36'd0);
    @(negedge clk);
    chk("lat_two_edges", 36'(bus.out_valid), 36'd1);
    chk("add_ovf_y", 36'(bus.y), 36'h080000000);
    chk("add_ovf_flags", 36'({bus.zero, bus.neg, bus.carry, bus.ovf}), 36'b0101);
    @(negedge clk);
    chk("sticky_after_add", 36'(bus.sticky_ovf), 36'd1);

    // Three ANDs keep the sticky overflow.
    for (int i = 0; i < 3; i++) run_vec(3);
    align();
    @(negedge clk);
    chk("sticky_after_ands", 36'(bus.sticky_ovf), 36'd1);

    // Clear together with a flag-free transfer drops the old sticky value.
    align();
    bus.out_ready = 1'b0;
    send(32'hFF, 32'h0F, 3'd2);
    wait_out();
    align();
    bus.clr_sticky = 1'b1;
    bus.out_ready  = 1'b1;
    align();
    bus.clr_sticky = 1'b0;
    @(negedge clk);
    chk("clr_with_and", 36'({bus.sticky_ovf, bus.sticky_cy}), 36'b00);

    // Clear together with an overflowing SUB keeps that transfer's flags.
    align();
    bus.out_ready = 1'b0;
    send(32'h80000000, 32'h1, 3'd1);
    wait_out();
    chk("sub_ovf_y", 36'(bus.y), 36'h07FFFFFFF);
    align();
    bus.clr_sticky = 1'b1;
    bus.out_ready  = 1'b1;
    align();
    bus.clr_sticky = 1'b0;
    @(negedge clk);
    chk("clr_with_sub", 36'({bus.sticky_ovf, bus.sticky_cy}), 36'b11);

    // Lone clear.
    align();
    bus.clr_sticky = 1'b1;
    align();
    bus.clr_sticky = 1'b0;
    @(negedge clk);
    chk("lone_clr", 36'({bus.sticky_ovf, bus.sticky_cy}), 36'b00);

    // Directed table, one beat at a time.
    for (int i = 0; i < NV; i++) run_vec(i);
    drain();

    // Four back-to-back beats with a 3-cycle stall mid-stream.
    align();
    bus.out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(t_a[stall_idx[i]], t_b[stall_idx[i]], t_op[stall_idx[i]]);
      end
      begin
        wait_out();
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        held_y = bus.y;
        chk("stall_first_y", 36'(held_y), 36'(t_y[stall_idx[1]]));
        chk("stall_in_ready0", 36'(bus.in_ready), 36'd0);
        for (int k = 1; k < 3; k++) begin
          @(negedge clk);
          chk($sformatf("stall_hold%0d", k), 36'(bus.y), 36'(held_y));
          chk($sformatf("stall_in_ready%0d", k), 36'(bus.in_ready), 36'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset while stalled with both stages full.
    align();
    send(32'h7FFFFFFF, 32'h1, 3'd0);
    wait_out();
    align();
    bus.out_ready = 1'b0;
    send(32'd3, 32'd4, 3'd0);
    send(32'd9, 32'd2, 3'd1);
    wait_out();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 36'(bus.out_valid), 36'd0);
    chk("async_rst_y", 36'(bus.y), 36'd0);
    chk("async_rst_flags", 36'({bus.zero, bus.neg, bus.carry, bus.ovf}), 36'd0);
    chk("async_rst_sticky", 36'({bus.sticky_ovf, bus.sticky_cy}), 36'd0);
    chk("async_rst_in_ready", 36'(bus.in_ready), 36'd1);
    align();
    align();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send(32'd6, 32'd7, 3'd0);
    @(negedge clk);
    chk("rst_lat_one_edge", 36'(bus.out_valid), 36'd0);
    @(negedge clk);
    chk("rst_lat_two_edges", 36'(bus.out_valid), 36'd1);
    chk("rst_first_y", 36'(bus.y), 36'd13);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
